fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. Holds the PC, issues requests to instruction memory through a ready handshake and loads the IF/ID pipeline register. It supplies opcode and func to the instruction decoder and consumes the decoder's PCSrc and branch outcome to redirect the PC, squashing the wrong-path fetch.

---
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the pipelined MIPS core: PC, imem handshake, IF/ID register.
// Latency: the word fetched in cycle N is presented on ifid_* in cycle N+1 with a zero-wait memory.
// Backpressure: a hazard stall parks a returned word in hold_buf (no request issued) until stall falls.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   imem_req/addr/ready/rdata   single-outstanding fetch handshake; rdata valid with ready
//   stall                 hazard-unit hold of IF/ID
//   pc_src, branch_taken  decoder redirect controls (2 = jump, 3 = jr)
//   branch_target, jr_target   ID-computed redirect targets
//   ifid_instr/pc4/valid  IF/ID pipeline register
//   opcode, func          decoder fields, zeroed for bubbles
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jr_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  func
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] req_addr, req_addr_nx;
  logic [31:0] hold_buf, hold_buf_nx;
  logic [31:0] instr_nx, pc4_nx;
  logic        valid_nx;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // A redirect is only honoured for a real instruction that is leaving ID this cycle.
  assign redirect = ifid_valid & ~stall & (pc_src[1] | branch_taken);
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    target = branch_target;
    if (pc_src == 2'd3)
      target = jr_target;
    else if (pc_src == 2'd2)
      target = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};
  end

  // The address presented to memory is always the registered request address,
  // so it cannot move while a request is outstanding.
  assign imem_addr = req_addr;

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    req_addr_nx = req_addr;
    hold_buf_nx = hold_buf;
    instr_nx    = ifid_instr;
    pc4_nx      = ifid_pc4;
    valid_nx    = ifid_valid;
    imem_req    = 1'b0;

    case (state)
      FETCH: begin
        imem_req = ~reset;
        if (imem_ready) begin
          if (redirect) begin
            // Wrong-path word is dropped; no delay slot.
            pc_nx       = target;
            req_addr_nx = target;
            valid_nx    = 1'b0;
          end else if (stall) begin
            // Park the word; req_addr stays so HOLD knows nothing new was asked for.
            hold_buf_nx = imem_rdata;
            pc_nx       = pc_plus4;
            state_nx    = HOLD;
          end else begin
            instr_nx    = imem_rdata;
            pc4_nx      = pc_plus4;
            valid_nx    = 1'b1;
            pc_nx       = pc_plus4;
            req_addr_nx = pc_plus4;
          end
        end else if (redirect) begin
          // Request still in flight: keep its address stable and drain it first.
          pc_nx    = target;
          valid_nx = 1'b0;
          state_nx = DRAIN;
        end else if (!stall) begin
          // ID consumed the current instruction and nothing replaces it yet.
          valid_nx = 1'b0;
        end
      end

      HOLD: begin
        if (!stall) begin
          if (redirect) begin
            pc_nx       = target;
            req_addr_nx = target;
            valid_nx    = 1'b0;
          end else begin
            instr_nx    = hold_buf;
            pc4_nx      = pc;
            valid_nx    = 1'b1;
            req_addr_nx = pc;
          end
          state_nx = FETCH;
        end
      end

      DRAIN: begin
        imem_req = ~reset;
        if (imem_ready) begin
          req_addr_nx = pc;
          state_nx    = FETCH;
        end
      end

      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      hold_buf   <= 32'd0;
      ifid_instr <= 32'd0;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      req_addr   <= req_addr_nx;
      hold_buf   <= hold_buf_nx;
      ifid_instr <= instr_nx;
      ifid_pc4   <= pc4_nx;
      ifid_valid <= valid_nx;
    end
  end

  assign opcode = ifid_valid ? ifid_instr[31:26] : 6'd0;
  assign func   = ifid_valid ? ifid_instr[5:0]   : 6'd0;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] jr_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  opcode;
  logic [5:0]  func;

  // Second instance exercising PC wrap-around.
  logic        w_reset;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_valid;
  logic [5:0]  w_opcode;
  logic [5:0]  w_func;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // Instruction memory image: addi-like filler tagged with its address,
  // plus j 0x40 at 0xC, jr $31 at 0x44, beq (-> 0x20) at 0x104.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_000C: mem_word = 32'h0800_0010;
      32'h0000_0044: mem_word = 32'h03E0_0008;
      32'h0000_0104: mem_word = 32'h1000_FFC6;
      default:       mem_word = {6'd8, 10'd0, a[15:0]};
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  fetch_stage u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .pc_src(pc_src), .branch_taken(branch_taken),
    .branch_target(branch_target), .jr_target(jr_target),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .opcode(opcode), .func(func)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(w_reset),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1), .imem_rdata(w_rdata),
    .stall(1'b0), .pc_src(2'd0), .branch_taken(1'b0),
    .branch_target(32'd0), .jr_target(32'd0),
    .ifid_instr(w_instr), .ifid_pc4(w_pc4), .ifid_valid(w_valid),
    .opcode(w_opcode), .func(w_func)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        stl;
    logic [1:0]  psrc;
    logic        bt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rst, input logic rdy, input logic stl,
                              input logic [1:0] psrc, input logic bt,
                              input logic req, input logic [31:0] addr, input logic valid,
                              input logic [31:0] instr, input logic [31:0] pc4);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.stl = stl; v.psrc = psrc; v.bt = bt;
    v.req = req; v.addr = addr; v.valid = valid; v.instr = instr; v.pc4 = pc4;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    // rst rdy stl psrc bt | req addr valid instr pc4
    vecs[0]  = mk(1, 1, 0, 0, 0,  0, 32'h000, 0, 32'h0000_0000, 32'h000);
    vecs[1]  = mk(0, 1, 0, 0, 0,  1, 32'h000, 0, 32'h0000_0000, 32'h000);
    vecs[2]  = mk(0, 1, 0, 0, 0,  1, 32'h004, 1, 32'h2000_0000, 32'h004);
    vecs[3]  = mk(0, 1, 0, 0, 0,  1, 32'h008, 1, 32'h2000_0004, 32'h008);
    vecs[4]  = mk(0, 1, 0, 0, 0,  1, 32'h00C, 1, 32'h2000_0008, 32'h00C);
    vecs[5]  = mk(0, 1, 0, 2, 0,  1, 32'h010, 1, 32'h0800_0010, 32'h010);
    vecs[6]  = mk(0, 1, 0, 0, 0,  1, 32'h040, 0, 32'h0800_0010, 32'h010);
    vecs[7]  = mk(0, 1, 0, 0, 0,  1, 32'h044, 1, 32'h2000_0040, 32'h044);
    vecs[8]  = mk(0, 0, 0, 3, 0,  1, 32'h048, 1, 32'h03E0_0008, 32'h048);
    vecs[9]  = mk(0, 0, 0, 3, 0,  1, 32'h048, 0, 32'h03E0_0008, 32'h048);
    vecs[10] = mk(0, 0, 0, 3, 0,  1, 32'h048, 0, 32'h03E0_0008, 32'h048);
    vecs[11] = mk(0, 1, 0, 3, 0,  1, 32'h048, 0, 32'h03E0_0008, 32'h048);
    vecs[12] = mk(0, 1, 0, 0, 0,  1, 32'h100, 0, 32'h03E0_0008, 32'h048);
    vecs[13] = mk(0, 1, 0, 0, 0,  1, 32'h104, 1, 32'h2000_0100, 32'h104);
    vecs[14] = mk(0, 1, 1, 0, 1,  1, 32'h108, 1, 32'h1000_FFC6, 32'h108);
    vecs[15] = mk(0, 1, 1, 0, 1,  0, 32'h108, 1, 32'h1000_FFC6, 32'h108);
    vecs[16] = mk(0, 1, 0, 0, 1,  0, 32'h108, 1, 32'h1000_FFC6, 32'h108);
    vecs[17] = mk(0, 1, 0, 0, 0,  1, 32'h020, 0, 32'h1000_FFC6, 32'h108);
    vecs[18] = mk(0, 1, 0, 0, 0,  1, 32'h024, 1, 32'h2000_0020, 32'h024);
    vecs[19] = mk(0, 0, 0, 0, 0,  1, 32'h028, 1, 32'h2000_0024, 32'h028);
    vecs[20] = mk(1, 0, 0, 0, 0,  0, 32'h028, 0, 32'h2000_0024, 32'h028);
    vecs[21] = mk(0, 1, 0, 0, 0,  1, 32'h000, 0, 32'h0000_0000, 32'h000);
    vecs[22] = mk(0, 1, 0, 0, 0,  1, 32'h004, 1, 32'h2000_0000, 32'h004);
    vecs[23] = mk(0, 1, 1, 0, 0,  1, 32'h008, 1, 32'h2000_0004, 32'h008);
    vecs[24] = mk(0, 1, 1, 0, 0,  0, 32'h008, 1, 32'h2000_0004, 32'h008);
    vecs[25] = mk(0, 1, 1, 0, 0,  0, 32'h008, 1, 32'h2000_0004, 32'h008);
    vecs[26] = mk(0, 1, 1, 0, 0,  0, 32'h008, 1, 32'h2000_0004, 32'h008);
    vecs[27] = mk(0, 1, 0, 0, 0,  0, 32'h008, 1, 32'h2000_0004, 32'h008);
    vecs[28] = mk(0, 1, 0, 0, 0,  1, 32'h00C, 1, 32'h2000_0008, 32'h00C);

    reset         = 1'b1;
    w_reset       = 1'b1;
    imem_ready    = 1'b1;
    stall         = 1'b0;
    pc_src        = 2'd0;
    branch_taken  = 1'b0;
    branch_target = 32'h0000_0020;
    jr_target     = 32'h0000_0100;

    for (int i = 0; i < NVEC; i++) begin
      logic [5:0] exp_op;
      logic [5:0] exp_fn;
      @(negedge clk);
      reset        = vecs[i].rst;
      imem_ready   = vecs[i].rdy;
      stall        = vecs[i].stl;
      pc_src       = vecs[i].psrc;
      branch_taken = vecs[i].bt;
      #1;
      exp_op = vecs[i].valid ? vecs[i].instr[31:26] : 6'd0;
      exp_fn = vecs[i].valid ? vecs[i].instr[5:0]   : 6'd0;
      chk("imem_req",   i, {31'd0, imem_req},   {31'd0, vecs[i].req});
      chk("imem_addr",  i, imem_addr,           vecs[i].addr);
      chk("ifid_valid", i, {31'd0, ifid_valid}, {31'd0, vecs[i].valid});
      chk("ifid_instr", i, ifid_instr,          vecs[i].instr);
      chk("ifid_pc4",   i, ifid_pc4,            vecs[i].pc4);
      chk("opcode",     i, {26'd0, opcode},     {26'd0, exp_op});
      chk("func",       i, {26'd0, func},       {26'd0, exp_fn});
    end

    // PC wrap: reset vector at the top of the address space.
    @(negedge clk);
    #1;
    chk("wrap_req_in_reset", 100, {31'd0, w_req}, 32'd0);
    chk("wrap_addr_in_reset", 100, w_addr, 32'hFFFF_FFFC);

    @(negedge clk);
    w_reset = 1'b0;
    #1;
    chk("wrap_req_first", 101, {31'd0, w_req}, 32'd1);
    chk("wrap_addr_first", 101, w_addr, 32'hFFFF_FFFC);
    chk("wrap_valid_first", 101, {31'd0, w_valid}, 32'd0);
    chk("wrap_opcode_bubble", 101, {26'd0, w_opcode}, 32'd0);
    chk("wrap_func_bubble", 101, {26'd0, w_func}, 32'd0);

    @(negedge clk);
    #1;
    chk("wrap_addr_second", 102, w_addr, 32'h0000_0000);
    chk("wrap_valid_second", 102, {31'd0, w_valid}, 32'd1);
    chk("wrap_pc4_second", 102, w_pc4, 32'h0000_0000);
    chk("wrap_instr_second", 102, w_instr, 32'h2000_FFFC);
    chk("wrap_opcode_second", 102, {26'd0, w_opcode}, 32'd8);
    chk("wrap_func_second", 102, {26'd0, w_func}, 32'h3C);

    @(negedge clk);
    #1;
    chk("wrap_addr_third", 103, w_addr, 32'h0000_0004);
    chk("wrap_pc4_third", 103, w_pc4, 32'h0000_0004);
    chk("wrap_instr_third", 103, w_instr, 32'h2000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
